// File: rtl/bus_responder_if.sv
// Slave-side 8085 bus bundle: CPU-driven address/data/status/strobes
// plus the responder's READY, read data and status flags.
interface bus_responder_if;
    logic       ale;
    logic [7:0] addr_hi;
    logic [7:0] ad_in;
    logic       iom_;
    logic       s1;
    logic       s0;
    logic       rd_;
    logic       wr_;
    logic       ready;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       hit;
    logic       err;

    modport master (
        output ale, addr_hi, ad_in, iom_, s1, s0, rd_, wr_,
        input  ready, ad_out, ad_oe, hit, err
    );

    modport slave (
        input  ale, addr_hi, ad_in, iom_, s1, s0, rd_, wr_,
        output ready, ad_out, ad_oe, hit, err
    );
endinterface

// File: rtl/bus_responder.sv
// 8085 bus responder: latches the multiplexed address on ALE, decodes a
// 2^LOCSIZE byte window, inserts WAITS wait states via READY and serves
// read/write cycles from a small byte store.
module bus_responder #(
    parameter int          LOCSIZE = 4,
    parameter logic [15:0] BASE    = 16'h2000,
    parameter logic        IOSPACE = 1'b0,
    parameter int          WAITS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    bus_responder_if.slave  bus
);

    localparam int          DEPTH   = 1 << LOCSIZE;
    localparam logic [15:0] HI_MASK = 16'hFFFF << LOCSIZE;
    localparam logic [3:0]  WAITS_C = 4'(WAITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t               state_q, state_d;
    logic [LOCSIZE-1:0]   idx_q, idx_d;
    logic                 is_wr_q, is_wr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [7:0]           ad_out_q, ad_out_d;
    logic                 ad_oe_q, ad_oe_d;
    logic                 hit_q, hit_d;
    logic                 err_q, err_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 commit;

    logic [DEPTH*8-1:0]   store_flat;
    logic [7:0]           rd_byte;
    logic [15:0]          bus_addr;
    logic                 sel;
    logic                 rd_low;
    logic                 wr_low;

    assign bus_addr = {bus.addr_hi, bus.ad_in};
    assign rd_low   = !bus.rd_;
    assign wr_low   = !bus.wr_;

    // Selection: right space, upper address bits match, and never INTA
    // (IO/M_=1, S1S0=11) or halt (S1S0=00).
    assign sel = (bus.iom_ == IOSPACE)
              && ((bus_addr & HI_MASK) == (BASE & HI_MASK))
              && !(bus.s1 & bus.s0 & bus.iom_)
              && (bus.s1 | bus.s0);

    assign rd_byte = store_flat[{idx_q, 3'b000} +: 8];

    // Byte store: one register per location, cleared by reset, written
    // only when a write cycle completes cleanly.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_store
        logic [7:0] byte_q;

        // Per-byte write on commit to this index.
        always_ff @(posedge clk) begin
            if (rst) begin
                byte_q <= '0;
            end else if (commit && (idx_q == LOCSIZE'(gi))) begin
                byte_q <= wdata_q;
            end
        end

        assign store_flat[gi*8 +: 8] = byte_q;
    end

    // Next-state and output logic; ALE overrides everything and aborts
    // any cycle in progress.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        is_wr_d  = is_wr_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        ad_out_d = ad_out_q;
        ad_oe_d  = ad_oe_q;
        hit_d    = hit_q;
        err_d    = 1'b0;
        wdata_d  = wdata_q;
        commit   = 1'b0;

        if (bus.ale) begin
            idx_d   = bus_addr[LOCSIZE-1:0];
            ready_d = 1'b1;
            ad_oe_d = 1'b0;
            hit_d   = sel;
            state_d = sel ? S_ADDR : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_d = 1'b1;
                    ad_oe_d = 1'b0;
                end

                S_ADDR: begin
                    if (rd_low && wr_low) begin
                        err_d   = 1'b1;
                        hit_d   = 1'b0;
                        state_d = S_IDLE;
                    end else if (rd_low || wr_low) begin
                        is_wr_d = wr_low;
                        if (wr_low) begin
                            wdata_d = bus.ad_in;
                        end
                        if (WAITS == 0) begin
                            state_d = S_ACCESS;
                            if (!wr_low) begin
                                ad_out_d = rd_byte;
                                ad_oe_d  = 1'b1;
                            end
                        end else begin
                            ready_d = 1'b0;
                            cnt_d   = WAITS_C;
                            state_d = S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    cnt_d = cnt_q - 4'd1;
                    // Keep tracking write data so a short strobe still
                    // commits the last value it carried.
                    if (is_wr_q && wr_low) begin
                        wdata_d = bus.ad_in;
                    end
                    if (cnt_q == 4'd1) begin
                        ready_d = 1'b1;
                        state_d = S_ACCESS;
                        if (!is_wr_q) begin
                            ad_out_d = rd_byte;
                            ad_oe_d  = 1'b1;
                        end
                    end
                end

                S_ACCESS: begin
                    if (is_wr_q) begin
                        if (rd_low) begin
                            err_d   = 1'b1;
                            hit_d   = 1'b0;
                            state_d = S_IDLE;
                        end else if (wr_low) begin
                            wdata_d = bus.ad_in;
                        end else begin
                            commit  = 1'b1;
                            hit_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        if (wr_low) begin
                            err_d   = 1'b1;
                            ad_oe_d = 1'b0;
                            hit_d   = 1'b0;
                            state_d = S_IDLE;
                        end else if (!rd_low) begin
                            ad_oe_d = 1'b0;
                            hit_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            is_wr_q  <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            is_wr_q  <= is_wr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.hit    = hit_q;
    assign bus.err    = err_q;

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Slave-side 8085 bus interface: the responder end of the CPU bus produced by the core's control unit.
- Demultiplexes the AD bus on ALE, decodes the address and IO/M_, and serves read/write cycles from a small internal byte store.
- Inserts a programmable number of wait states by pulling READY low.
- Sits on the system bus next to the core as the memory/IO device model, and serves as a bench target for the core.

Parameters:
- LOCSIZE, 4, address bits decoded inside the block; the store holds 2^LOCSIZE bytes.
- BASE, 16'h2000, base address; the upper 16-LOCSIZE bits must match for a hit.
- IOSPACE, 1'b0, required IO/M_ level for a hit (0 = memory-mapped, 1 = IO-mapped).
- WAITS, 1, READY-low cycles per access, range 0..15.

Ports:
- clk  input  1  system clock; all inputs sampled on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ale  input  1  address latch enable from the CPU.
- addr_hi  input  8  A15-A8.
- ad_in  input  8  AD7-AD0 as driven by the CPU (low address, then write data).
- iom_  input  1  IO/M_ status.
- s1  input  1  status bit S1.
- s0  input  1  status bit S0.
- rd_  input  1  read strobe, active low.
- wr_  input  1  write strobe, active low.
- ready  output  1  READY to the CPU; low inserts wait states.
- ad_out  output  8  read data for AD7-AD0.
- ad_oe  output  1  high when this block drives AD7-AD0.
- hit  output  1  high from address latch until cycle end while selected.
- err  output  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (rst high at a clock edge): state IDLE, ready=1, ad_out=0, ad_oe=0, hit=0, err=0. All store bytes cleared to 0. Reset mid-cycle aborts the cycle; no store write is committed.
- Address latch: when ale=1 is sampled in any state, latch addr={addr_hi,ad_in}.
  - sel = (iom_==IOSPACE) && addr[15:LOCSIZE]==BASE[15:LOCSIZE] && !(s1&s0&iom_).
  - INTA (iom_=1, s1s0=11) and halt cycles (s1s0=00) never select.
  - sel=1: next ADDR, hit=1.
  - sel=0: next IDLE, hit=0.
  - ALE in a non-IDLE state aborts the current cycle: no write commit, ad_oe=0, ready=1.
- States:
  - IDLE: ready=1, ad_oe=0. Waits for ALE.
  - ADDR: waits for a strobe.
    - rd_=0 and wr_=0 both sampled low: err=1 for one cycle, go to IDLE, hit=0.
    - rd_=0 or wr_=0 sampled low with WAITS=0: go to ACCESS.
    - Otherwise: ready<=0, cnt<=WAITS, go to WAIT.
    - Strobe type (read/write) is latched at this point.
  - WAIT: ready=0 and cnt decrements each cycle. When cnt==1, ready<=1 and next ACCESS. READY is low for exactly WAITS clock cycles.
  - ACCESS read: ad_out<=store[addr[LOCSIZE-1:0]] and ad_oe<=1 on ACCESS entry for WAITS=0, or on the ready rise for WAITS>0. Held until rd_ is sampled high; then ad_oe<=0, hit<=0, IDLE. ad_out keeps its last value after the cycle.
  - ACCESS write: wdata<=ad_in on every clock while wr_ is sampled low. When wr_ is sampled high: store[addr]<=wdata (last low-sampled value), hit<=0, IDLE.
- A strobe change to the opposite type during ACCESS: err pulse, cycle aborted, no commit.
- Only the low LOCSIZE address bits index the store. Addresses wrap within the block's window; nothing outside the window is decoded.
- Latency: read data valid at most 1 clock after READY returns high (same edge for WAITS=0).

Test Plan:
- Reset with rst=1 for 2 clocks -> ready=1, ad_oe=0, hit=0, err=0; then a read of 16'h2003 returns 8'h00.
- WAITS=1: ALE addr 16'h2005, wr_ low 3 clocks with ad_in=8'hA5, wr_ high; then read 16'h2005 -> ready low exactly 1 clock after each strobe, ad_oe=1, ad_out=8'hA5.
- Miss: ALE addr 16'h3005 and addr 16'h2005 with iom_=1 (IOSPACE=0) -> hit=0, ready stays 1, ad_oe never asserted, store unchanged.
- INTA cycle: iom_=1, s1s0=11, addr 16'h2001, IOSPACE=1 -> hit=0, no response.
- Violation: rd_ and wr_ low together after a hit on 16'h2002 -> err high 1 cycle, IDLE, ready=1, store[2] unchanged.
- Abort: rst or a new ALE during WAIT of a write to 16'h200F -> ready=1 next cycle, store[15] keeps its old value; wrap check: 16'h201F not decoded (miss), 16'h200F indexes byte 15.
